enemy_pixel_sequencer: RTL and testbench

Per-pixel sequencer that shares the single combinational enemy colour palette among `N_ENEMY` enemy sprite layers. On each `start` strobe it latches every layer's 4-bit palette index and walks the layers in fixed priority order (slot 0 highest), one palette lookup per cycle. It returns the RGB of the first opaque pixel, or reports "no hit" so the frame compositor shows the background. It sits between the enemy sprite ROM readers and the VGA pixel mux.

---
 rtl/enemy_pixel_sequencer.sv | 174 +++++++++++++++++
 tb/tb_enemy_pixel_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_pixel_sequencer.sv
// Per-pixel enemy layer resolver: walks the latched sprite layers in priority order through
// one shared palette port and reports the first opaque colour, or no hit.
module enemy_pixel_sequencer #(
    parameter int unsigned N_ENEMY = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic [4*N_ENEMY-1:0]   idx_bus,
    input  logic [N_ENEMY-1:0]     enable,
    output logic [3:0]             pal_index,
    input  logic [7:0]             pal_red,
    input  logic [7:0]             pal_green,
    input  logic [7:0]             pal_blue,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic [7:0]             red_out,
    output logic [7:0]             green_out,
    output logic [7:0]             blue_out,
    output logic [3:0]             slot_out,
    output logic                   bad_idx
);

    localparam int unsigned SlotW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [SlotW-1:0] LastSlot = SlotW'(N_ENEMY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [SlotW-1:0]     slot_q, slot_d;
    logic [4*N_ENEMY-1:0] idx_q, idx_d;
    logic [N_ENEMY-1:0]   en_q, en_d;
    logic                 hit_q, hit_d;
    logic [7:0]           red_q, red_d;
    logic [7:0]           green_q, green_d;
    logic [7:0]           blue_q, blue_d;
    logic [3:0]           slot_out_q, slot_out_d;
    logic                 bad_q, bad_d;

    logic [3:0] cur_idx;
    logic       cur_en;
    logic       cur_opaque;
    logic       cur_bad;
    logic       last_slot;

    // Select the layer currently under evaluation from the latched snapshot.
    always_comb begin
        cur_idx = 4'd0;
        cur_en  = 1'b0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            if (slot_q == SlotW'(i)) begin
                cur_idx = idx_q[4*i +: 4];
                cur_en  = en_q[i];
            end
        end
    end

    // Index 0 is the transparent key; 9..15 are illegal and treated as transparent.
    assign cur_opaque = cur_en && (cur_idx != 4'd0) && (cur_idx <= 4'd8);
    assign cur_bad    = cur_en && (cur_idx >= 4'd9);
    assign last_slot  = (slot_q == LastSlot);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_opaque || last_slot) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        pal_index = (state_q == StScan) ? cur_idx : 4'd0;
    end

    always_comb begin
        slot_d     = slot_q;
        idx_d      = idx_q;
        en_d       = en_q;
        hit_d      = hit_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        slot_out_d = slot_out_q;
        bad_d      = bad_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d  = idx_bus;
                    en_d   = enable;
                    slot_d = '0;
                end
            end
            StScan: begin
                if (cur_bad) begin
                    bad_d = 1'b1;
                end
                if (cur_opaque) begin
                    hit_d      = 1'b1;
                    red_d      = pal_red;
                    green_d    = pal_green;
                    blue_d     = pal_blue;
                    slot_out_d = 4'(slot_q);
                end else if (last_slot) begin
                    hit_d      = 1'b0;
                    red_d      = 8'd0;
                    green_d    = 8'd0;
                    blue_d     = 8'd0;
                    slot_out_d = 4'd0;
                end else begin
                    slot_d = slot_q + SlotW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_q     <= '0;
            idx_q      <= '0;
            en_q       <= '0;
            hit_q      <= 1'b0;
            red_q      <= 8'd0;
            green_q    <= 8'd0;
            blue_q     <= 8'd0;
            slot_out_q <= 4'd0;
            bad_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            en_q       <= en_d;
            hit_q      <= hit_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            slot_out_q <= slot_out_d;
            bad_q      <= bad_d;
        end
    end

    assign hit       = hit_q;
    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;
    assign slot_out  = slot_out_q;
    assign bad_idx   = bad_q;

endmodule

// File: tb/tb_enemy_pixel_sequencer.sv
// Directed bench for enemy_pixel_sequencer: a four-layer instance and a single-layer instance,
// each driven by a behavioural palette.
module tb_enemy_pixel_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;

    logic        start;
    logic [15:0] idx_bus;
    logic [3:0]  enable;
    logic [3:0]  pal_index;
    logic [7:0]  pal_red, pal_green, pal_blue;
    logic        busy, done, hit, bad_idx;
    logic [7:0]  red_out, green_out, blue_out;
    logic [3:0]  slot_out;

    logic        start1;
    logic [3:0]  idx1;
    logic [0:0]  en1;
    logic [3:0]  pal_index1;
    logic [7:0]  pal_red1, pal_green1, pal_blue1;
    logic        busy1, done1, hit1, bad_idx1;
    logic [7:0]  red1, green1, blue1;
    logic [3:0]  slot1;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pal_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    pal_lookup = 24'hffc0cb;
            4'd1:    pal_lookup = 24'h000000;
            4'd2:    pal_lookup = 24'h204060;
            4'd3:    pal_lookup = 24'h3d3d47;
            4'd4:    pal_lookup = 24'ha0a0a0;
            4'd5:    pal_lookup = 24'h918594;
            4'd6:    pal_lookup = 24'hc83030;
            4'd7:    pal_lookup = 24'h30c830;
            4'd8:    pal_lookup = 24'h3030c8;
            default: pal_lookup = 24'heeeeee;
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue}    = pal_lookup(pal_index);
    assign {pal_red1, pal_green1, pal_blue1} = pal_lookup(pal_index1);

    enemy_pixel_sequencer #(.N_ENEMY(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .idx_bus   (idx_bus),
        .enable    (enable),
        .pal_index (pal_index),
        .pal_red   (pal_red),
        .pal_green (pal_green),
        .pal_blue  (pal_blue),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .slot_out  (slot_out),
        .bad_idx   (bad_idx)
    );

    enemy_pixel_sequencer #(.N_ENEMY(1)) dut1 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start1),
        .idx_bus   (idx1),
        .enable    (en1),
        .pal_index (pal_index1),
        .pal_red   (pal_red1),
        .pal_green (pal_green1),
        .pal_blue  (pal_blue1),
        .busy      (busy1),
        .done      (done1),
        .hit       (hit1),
        .red_out   (red1),
        .green_out (green1),
        .blue_out  (blue1),
        .slot_out  (slot1),
        .bad_idx   (bad_idx1)
    );

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        idx_bus = 16'hffff;
        enable  = 4'hf;
        start1  = 1'b0;
        idx1    = 4'd0;
        en1     = 1'b1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_rgb", {red_out, green_out, blue_out}, 0);
        chk("rst_slot", slot_out, 0);
        chk("rst_pal_index", pal_index, 0);
        chk("rst_bad", bad_idx, 0);
        Reset_n = 1'b1;
        step();

        // Hit at slot 2
        idx_bus = 16'h2500;
        enable  = 4'b1111;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("t1_busy_t1", busy, 1);
        chk("t1_done_t1", done, 0);
        step();
        step();
        chk("t1_pal_index_t3", pal_index, 5);
        chk("t1_done_t3", done, 0);
        step();
        chk("t1_done_t4", done, 1);
        chk("t1_hit", hit, 1);
        chk("t1_slot", slot_out, 2);
        chk("t1_rgb", {red_out, green_out, blue_out}, 24'h918594);
        chk("t1_busy_t4", busy, 1);
        step();
        chk("t1_done_t5", done, 0);
        chk("t1_busy_t5", busy, 0);
        chk("t1_hold_rgb", {red_out, green_out, blue_out}, 24'h918594);

        // All transparent; late idx_bus change must not affect the pixel
        idx_bus = 16'h0000;
        start   = 1'b1;
        step();
        start   = 1'b0;
        idx_bus = 16'h5555;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t2_busy_t%0d", k), busy, 1);
            chk($sformatf("t2_done_t%0d", k), done, 0);
            step();
        end
        chk("t2_done_t5", done, 1);
        chk("t2_busy_t5", busy, 1);
        chk("t2_hit", hit, 0);
        chk("t2_rgb", {red_out, green_out, blue_out}, 0);
        chk("t2_slot", slot_out, 0);
        step();
        chk("t2_busy_t6", busy, 0);

        // Disabled layer 0, opaque black at slot 1
        idx_bus = 16'h0018;
        enable  = 4'b1110;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        step();
        chk("t3_done_t3", done, 1);
        chk("t3_hit", hit, 1);
        chk("t3_slot", slot_out, 1);
        chk("t3_rgb", {red_out, green_out, blue_out}, 0);
        chk("t3_bad", bad_idx, 0);
        step();

        // Illegal index at slot 0, sticky flag across next pixel
        idx_bus = 16'h003c;
        enable  = 4'b1111;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        step();
        chk("t4_done_t3", done, 1);
        chk("t4_bad", bad_idx, 1);
        chk("t4_slot", slot_out, 1);
        chk("t4_rgb", {red_out, green_out, blue_out}, 24'h3d3d47);
        step();
        idx_bus = 16'h0005;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        chk("t4b_done_t2", done, 1);
        chk("t4b_slot", slot_out, 0);
        chk("t4b_rgb", {red_out, green_out, blue_out}, 24'h918594);
        chk("t4b_bad_sticky", bad_idx, 1);
        step();

        // start while busy: at t+1 and on the DONE cycle
        idx_bus  = 16'h0700;
        start    = 1'b1;
        done_cnt = 0;
        step();
        chk("t5_busy_t1", busy, 1);
        done_cnt += int'(done);
        step();
        start = 1'b0;
        done_cnt += int'(done);
        step();
        done_cnt += int'(done);
        step();
        chk("t5_done_t4", done, 1);
        done_cnt += int'(done);
        start = 1'b1;
        step();
        start = 1'b0;
        done_cnt += int'(done);
        chk("t5_busy_t5", busy, 0);
        chk("t5_one_done", done_cnt, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_accept_busy", busy, 1);
        step();
        step();
        step();
        chk("t5_accept_done", done, 1);
        chk("t5_accept_slot", slot_out, 2);
        chk("t5_accept_rgb", {red_out, green_out, blue_out}, 24'h30c830);
        step();

        // Single-layer instance: both outcomes finish at t+2
        idx1   = 4'd4;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("n1_busy_t1", busy1, 1);
        chk("n1_done_t1", done1, 0);
        chk("n1_pal_index", pal_index1, 4);
        step();
        chk("n1_done_t2", done1, 1);
        chk("n1_hit", hit1, 1);
        chk("n1_rgb", {red1, green1, blue1}, 24'ha0a0a0);
        step();
        chk("n1_busy_t3", busy1, 0);
        idx1   = 4'd0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        chk("n1_miss_done_t2", done1, 1);
        chk("n1_miss_hit", hit1, 0);
        chk("n1_miss_rgb", {red1, green1, blue1}, 0);
        step();

        // Reset during slot 1 evaluation
        idx_bus = 16'h5000;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        #2 Reset_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_hit", hit, 0);
        chk("rs_rgb", {red_out, green_out, blue_out}, 0);
        chk("rs_slot", slot_out, 0);
        chk("rs_pal_index", pal_index, 0);
        chk("rs_bad", bad_idx, 0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            done_cnt += int'(done);
        end
        Reset_n = 1'b1;
        step();
        done_cnt += int'(done);
        chk("rs_no_done", done_cnt, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rs_done_t4", done, 0);
        step();
        chk("rs_done_t5", done, 1);
        chk("rs_hit_after", hit, 1);
        chk("rs_slot_after", slot_out, 3);
        chk("rs_rgb_after", {red_out, green_out, blue_out}, 24'h918594);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
